// File: rtl/mem_access_seq_if.sv
// Request/completion and memory-bus signals of mem_access_seq, bundled as one interface.
// The sequencer uses the slave modport; the requester/memory environment uses master.
interface mem_access_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    localparam int LANES = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  done;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  error;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [LANES-1:0]      mem_byte_enable;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_resp,
        output req_ready, done, rdata, error,
               mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_resp,
        input  req_ready, done, rdata, error,
               mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable
    );
endinterface

// File: rtl/mem_access_seq.sv
// Load/store sequencer: word, byte and pointer-indirect accesses over a strobe/resp memory bus.
// Optional access timeout is compiled in with `define MEM_TIMEOUT_EN.
module mem_access_seq #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    mem_access_seq_if.slave bus
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(LANES);
    localparam int PW    = ADDR_WIDTH - LSB;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 16) begin : g_bad_data_width
        $error("mem_access_seq: DATA_WIDTH must be a multiple of 8 and >= 16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_access_seq: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_e;

    localparam logic [2:0] OP_LDB = 3'd1;
    localparam logic [2:0] OP_LDI = 3'd2;
    localparam logic [2:0] OP_STW = 3'd3;
    localparam logic [2:0] OP_STB = 3'd4;
    localparam logic [2:0] OP_STI = 3'd5;

    state_e                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  error_q, error_d;

    logic [LSB-1:0]        lane;
    logic [7:0]            lane_byte;
    logic [DATA_WIDTH-1:0] load_value;
    logic                  indirect, is_store;
    logic                  acc_read, acc_write, timeout_hit;

    assign lane     = addr_q[LSB-1:0];
    assign indirect = (op_q == OP_LDI) || (op_q == OP_STI);
    assign is_store = (op_q == OP_STW) || (op_q == OP_STB) || (op_q == OP_STI);

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lane_byte = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LSB'(i)) lane_byte = bus.mem_rdata[i*8 +: 8];
        end
        load_value = (op_q == OP_LDB) ? {{(DATA_WIDTH-8){1'b0}}, lane_byte} : bus.mem_rdata;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Counts strobe cycles of the current access; restarts for the second access of LDI/STI.
    always_comb begin
        cnt_d = '0;
        if ((state_q == ACC1 || state_q == ACC2) && !bus.mem_resp) cnt_d = cnt_q + 1'b1;
    end

    assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // ACC1 reads the pointer for indirect ops; ACC2 only exists for LDI/STI.
    always_comb begin
        acc_read  = 1'b0;
        acc_write = 1'b0;
        if (state_q == ACC1) begin
            acc_read  = !is_store || indirect;
            acc_write = is_store && !indirect;
        end else if (state_q == ACC2) begin
            acc_read  = !is_store;
            acc_write = is_store;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    error_d = 1'b0;
                    if (bus.req_op > OP_STI) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = ACC1;
                    end
                end
            end
            ACC1: begin
                if (bus.mem_resp) begin
                    if (indirect) begin
                        ptr_d   = PW'(bus.mem_rdata >> LSB);
                        state_d = ACC2;
                    end else begin
                        if (!is_store) rdata_d = load_value;
                        state_d = DONE;
                    end
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end
            end
            ACC2: begin
                if (bus.mem_resp) begin
                    if (!is_store) rdata_d = bus.mem_rdata;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                rdata_d = '0;
                error_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_address     = '0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata       = '0;
        if (state_q == ACC1) begin
            bus.mem_address = {addr_q[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
            if (op_q == OP_STB) begin
                bus.mem_byte_enable = LANES'(1) << lane;
                bus.mem_wdata       = {LANES{wdata_q[7:0]}};
            end else begin
                bus.mem_byte_enable = '1;
                if (acc_write) bus.mem_wdata = wdata_q;
            end
        end else if (state_q == ACC2) begin
            bus.mem_address     = {ptr_q, {LSB{1'b0}}};
            bus.mem_byte_enable = '1;
            if (acc_write) bus.mem_wdata = wdata_q;
        end
    end

    assign bus.mem_read  = acc_read;
    assign bus.mem_write = acc_write;
    assign bus.req_ready = (state_q == IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.rdata     = rdata_q;
    assign bus.error     = error_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            ptr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end
endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: directed vector table, reset/idle corner sequences,
// and randomized transactions checked against a word-array memory model.
module tb_mem_access_seq;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int TO    = 4;
    localparam int LANES = DW / 8;

    localparam logic [2:0] LDW = 3'd0, LDB = 3'd1, LDI = 3'd2, STW = 3'd3, STB = 3'd4, STI = 3'd5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_access_seq #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [logic [AW-1:0]];

    typedef struct {
        int             lat;
        logic [DW-1:0]  rdata;
        logic           err;
        int             strobes;
        logic [AW-1:0]  addr1;
        logic [LANES-1:0] be1;
        logic [DW-1:0]  wdata1;
        logic [AW-1:0]  addr2;
        logic           chk_mem;
        logic [AW-1:0]  mem_a;
        logic [DW-1:0]  mem_v;
    } exp_t;

    typedef struct {
        logic           ready_at_req;
        logic           got_done;
        int             lat;
        logic [DW-1:0]  rdata;
        logic           err;
        int             strobes;
        logic [AW-1:0]  addr1;
        logic [LANES-1:0] be1;
        logic [DW-1:0]  wdata1;
        logic [AW-1:0]  addr2;
        logic           unstable;
        logic           ready_after;
        logic           done_after;
    } obs_t;

    typedef struct {
        string          name;
        logic [2:0]     op;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        int             d1;
        int             d2;
        logic [AW-1:0]  p0a;
        logic [DW-1:0]  p0d;
        logic [AW-1:0]  p1a;
        logic [DW-1:0]  p1d;
        exp_t           e;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~AW'(LANES - 1);
    endfunction

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(align(a)) ? mem[align(a)] : '0;
    endfunction

    function automatic void mem_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LANES-1:0] be);
        logic [DW-1:0] w;
        w = mem_rd(a);
        for (int i = 0; i < LANES; i++) if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
        mem[align(a)] = w;
    endfunction

    // Expected outcome of one request, from the operation rules and the current memory image.
    function automatic exp_t model(input logic [2:0] op, input logic [AW-1:0] addr,
                                   input logic [DW-1:0] wdata, input int d1, input int d2);
        exp_t e;
        logic [AW-1:0] al, p;
        logic [DW-1:0] w;
        int bi;
        al = align(addr);
        bi = int'(addr % LANES);
        e = '{lat: 1 + (d1 + 1), rdata: '0, err: 1'b0, strobes: d1 + 1, addr1: al, be1: '1,
              wdata1: '0, addr2: '0, chk_mem: 1'b0, mem_a: '0, mem_v: '0};
        case (op)
            LDW: e.rdata = mem_rd(al);
            LDB: begin
                w = mem_rd(al);
                e.rdata = (w >> (8 * bi)) & DW'(8'hFF);
            end
            LDI, STI: begin
                p = AW'(mem_rd(al));
                e.addr2   = align(p);
                e.lat     = 1 + (d1 + 1) + (d2 + 1);
                e.strobes = d1 + d2 + 2;
                if (op == LDI) e.rdata = mem_rd(p);
                else begin
                    e.chk_mem = 1'b1;
                    e.mem_a   = align(p);
                    e.mem_v   = wdata;
                end
            end
            STW: begin
                e.wdata1  = wdata;
                e.chk_mem = 1'b1;
                e.mem_a   = al;
                e.mem_v   = wdata;
            end
            STB: begin
                e.be1    = LANES'(1) << bi;
                e.wdata1 = {LANES{wdata[7:0]}};
                w = mem_rd(al);
                w[bi*8 +: 8] = wdata[7:0];
                e.chk_mem = 1'b1;
                e.mem_a   = al;
                e.mem_v   = w;
            end
            default: begin
                e.err = 1'b1; e.lat = 1; e.strobes = 0; e.addr1 = '0; e.be1 = '0;
            end
        endcase
        return e;
    endfunction

    // Issues one request at a negedge and acts as the memory; returns at a negedge with the DUT idle.
    task automatic run_txn(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int d1, input int d2, output obs_t o);
        int held, acc;
        logic [AW-1:0] cur_a;
        logic [LANES-1:0] cur_be;
        logic [DW-1:0] cur_wd;
        logic cur_rd, cur_wr;
        o = '{ready_at_req: bus.req_ready, got_done: 1'b0, lat: 0, rdata: '0, err: 1'b0, strobes: 0,
              addr1: '0, be1: '0, wdata1: '0, addr2: '0, unstable: 1'b0, ready_after: 1'b0, done_after: 1'b0};
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        held = 0; acc = 0;
        cur_a = '0; cur_be = '0; cur_wd = '0; cur_rd = 1'b0; cur_wr = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.mem_resp  = 1'b0;
            bus.mem_rdata = DW'($urandom);
            if (bus.done) begin
                o.got_done = 1'b1;
                o.lat      = k;
                o.rdata    = bus.rdata;
                o.err      = bus.error;
                break;
            end
            if (bus.mem_read || bus.mem_write) begin
                if (held == 0) begin
                    acc++;
                    cur_a = bus.mem_address; cur_be = bus.mem_byte_enable; cur_wd = bus.mem_wdata;
                    cur_rd = bus.mem_read; cur_wr = bus.mem_write;
                    if (acc == 1) begin o.addr1 = cur_a; o.be1 = cur_be; o.wdata1 = cur_wd; end
                    if (acc == 2) o.addr2 = cur_a;
                end else if (cur_a !== bus.mem_address || cur_be !== bus.mem_byte_enable ||
                             cur_wd !== bus.mem_wdata || cur_rd !== bus.mem_read || cur_wr !== bus.mem_write) begin
                    o.unstable = 1'b1;
                end
                o.strobes++;
                held++;
                if (held == ((acc == 1) ? d1 : d2) + 1) begin
                    bus.mem_resp = 1'b1;
                    if (bus.mem_read) bus.mem_rdata = mem_rd(bus.mem_address);
                    else mem_wr(bus.mem_address, bus.mem_wdata, bus.mem_byte_enable);
                    held = 0;
                end
            end
        end
        @(negedge clk);
        bus.mem_resp  = 1'b0;
        o.ready_after = bus.req_ready;
        o.done_after  = bus.done;
    endtask

    task automatic cmp(input string tag, input logic [2:0] op, input exp_t e, input obs_t o);
        check({tag, ".ready"},     64'(o.ready_at_req), 64'(1));
        check({tag, ".done"},      64'(o.got_done),     64'(1));
        check({tag, ".latency"},   64'(o.lat),          64'(e.lat));
        check({tag, ".rdata"},     64'(o.rdata),        64'(e.rdata));
        check({tag, ".error"},     64'(o.err),          64'(e.err));
        check({tag, ".strobes"},   64'(o.strobes),      64'(e.strobes));
        check({tag, ".addr1"},     64'(o.addr1),        64'(e.addr1));
        check({tag, ".be1"},       64'(o.be1),          64'(e.be1));
        check({tag, ".stable"},    64'(o.unstable),     64'(0));
        check({tag, ".idle_after"},64'({o.ready_after, o.done_after}), 64'(2'b10));
        if (op == STW || op == STB) check({tag, ".wdata1"}, 64'(o.wdata1), 64'(e.wdata1));
        if (op == LDI || op == STI) check({tag, ".addr2"},  64'(o.addr2),  64'(e.addr2));
        if (e.chk_mem) check({tag, ".mem_word"}, 64'(mem_rd(e.mem_a)), 64'(e.mem_v));
    endtask

    task automatic add_vec(input string name, input logic [2:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int d1, input int d2,
                           input logic [AW-1:0] p0a, input logic [DW-1:0] p0d,
                           input logic [AW-1:0] p1a, input logic [DW-1:0] p1d,
                           input int lat, input logic [DW-1:0] rdata, input logic err, input int strobes,
                           input logic [AW-1:0] addr1, input logic [LANES-1:0] be1, input logic [DW-1:0] wdata1,
                           input logic [AW-1:0] addr2, input logic chk_mem,
                           input logic [AW-1:0] mem_a, input logic [DW-1:0] mem_v);
        vec_t v;
        v.name = name; v.op = op; v.addr = addr; v.wdata = wdata; v.d1 = d1; v.d2 = d2;
        v.p0a = p0a; v.p0d = p0d; v.p1a = p1a; v.p1d = p1d;
        v.e = '{lat: lat, rdata: rdata, err: err, strobes: strobes, addr1: addr1, be1: be1,
                wdata1: wdata1, addr2: addr2, chk_mem: chk_mem, mem_a: mem_a, mem_v: mem_v};
        vecs.push_back(v);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        exp_t e;
        logic bad;
        int wcount;

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.mem_rdata = '0; bus.mem_resp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.req_ready",  64'(bus.req_ready),       64'(1));
        check("rst.done",       64'(bus.done),            64'(0));
        check("rst.error",      64'(bus.error),           64'(0));
        check("rst.rdata",      64'(bus.rdata),           64'(0));
        check("rst.mem_read",   64'(bus.mem_read),        64'(0));
        check("rst.mem_write",  64'(bus.mem_write),       64'(0));
        check("rst.mem_address",64'(bus.mem_address),     64'(0));
        check("rst.mem_wdata",  64'(bus.mem_wdata),       64'(0));
        check("rst.mem_be",     64'(bus.mem_byte_enable), 64'(0));
        rst = 1'b0;

        // mem_resp while idle must not start or complete anything
        bad = 1'b0;
        bus.mem_resp = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.done || bus.mem_read || bus.mem_write || !bus.req_ready) bad = 1'b1;
        end
        bus.mem_resp = 1'b0;
        check("idle_resp_ignored", 64'(bad), 64'(0));

        //       name          op   addr      wdata     d1 d2 p0a       p0d       p1a       p1d       lat rdata     err str addr1     be     wdata1    addr2     mem a         v
        add_vec("ldw_1235",   LDW, 16'h1235, 16'h0000, 0, 0, 16'h1234, 16'hBEEF, 16'hFFF0, 16'h0000, 2, 16'hBEEF, 0, 1, 16'h1234, 2'b11, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000);
        add_vec("ldb_2001",   LDB, 16'h2001, 16'h0000, 0, 0, 16'h2000, 16'hA55A, 16'hFFF0, 16'h0000, 2, 16'h00A5, 0, 1, 16'h2000, 2'b11, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000);
        add_vec("ldb_2000",   LDB, 16'h2000, 16'h0000, 0, 0, 16'h2000, 16'hA55A, 16'hFFF0, 16'h0000, 2, 16'h005A, 0, 1, 16'h2000, 2'b11, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000);
        add_vec("stb_3001",   STB, 16'h3001, 16'h1234, 0, 0, 16'h3000, 16'hAAAA, 16'hFFF0, 16'h0000, 2, 16'h0000, 0, 1, 16'h3000, 2'b10, 16'h3434, 16'h0000, 1, 16'h3000, 16'h34AA);
        add_vec("stb_3000",   STB, 16'h3000, 16'h00C3, 1, 0, 16'h3000, 16'hAAAA, 16'hFFF0, 16'h0000, 3, 16'h0000, 0, 2, 16'h3000, 2'b01, 16'hC3C3, 16'h0000, 1, 16'h3000, 16'hAAC3);
        add_vec("ldi_4000",   LDI, 16'h4000, 16'h0000, 0, 0, 16'h4000, 16'h5000, 16'h5000, 16'h0042, 3, 16'h0042, 0, 2, 16'h4000, 2'b11, 16'h0000, 16'h5000, 0, 16'h0000, 16'h0000);
        add_vec("stw_wait2",  STW, 16'h1001, 16'hABCD, 2, 0, 16'h1000, 16'h0000, 16'hFFF0, 16'h0000, 4, 16'h0000, 0, 3, 16'h1000, 2'b11, 16'hABCD, 16'h0000, 1, 16'h1000, 16'hABCD);
        add_vec("sti_0100",   STI, 16'h0100, 16'h7777, 1, 0, 16'h0100, 16'h0203, 16'h0202, 16'h0000, 4, 16'h0000, 0, 3, 16'h0100, 2'b11, 16'h0000, 16'h0202, 1, 16'h0202, 16'h7777);
        add_vec("ldi_wait",   LDI, 16'h4001, 16'h0000, 1, 2, 16'h4000, 16'h5003, 16'h5002, 16'h1357, 6, 16'h1357, 0, 5, 16'h4000, 2'b11, 16'h0000, 16'h5002, 0, 16'h0000, 16'h0000);
        add_vec("illegal_7",  3'd7, 16'h1235, 16'hFFFF, 0, 0, 16'hFFF0, 16'h0000, 16'hFFF0, 16'h0000, 1, 16'h0000, 1, 0, 16'h0000, 2'b00, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000);
        add_vec("illegal_6",  3'd6, 16'h2001, 16'h5555, 0, 0, 16'hFFF0, 16'h0000, 16'hFFF0, 16'h0000, 1, 16'h0000, 1, 0, 16'h0000, 2'b00, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000);

        foreach (vecs[i]) begin
            mem[vecs[i].p0a] = vecs[i].p0d;
            mem[vecs[i].p1a] = vecs[i].p1d;
            run_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].d1, vecs[i].d2, o);
            cmp(vecs[i].name, vecs[i].op, vecs[i].e, o);
        end

        // STW with mem_resp withheld, reset after three strobe cycles, then a late response
        wcount = 0;
        bus.req_valid = 1'b1; bus.req_op = STW; bus.req_addr = 16'h0700; bus.req_wdata = 16'h2222;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.mem_write) wcount++;
        end
        check("abort.strobe_cycles", 64'(wcount), 64'(3));
        rst = 1'b1;
        @(negedge clk);
        check("abort.mem_write_low", 64'(bus.mem_write), 64'(0));
        check("abort.no_done",       64'(bus.done),      64'(0));
        check("abort.req_ready",     64'(bus.req_ready), 64'(1));
        rst = 1'b0;
        bus.mem_resp = 1'b1;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done || bus.mem_read || bus.mem_write || !bus.req_ready) bad = 1'b1;
        end
        bus.mem_resp = 1'b0;
        check("abort.late_resp_ignored", 64'(bad), 64'(0));

`ifdef MEM_TIMEOUT_EN
        mem[16'h0600] = 16'h9999;
        run_txn(STW, 16'h0600, 16'h1111, 1000, 0, o);
        check("timeout.done",    64'(o.got_done), 64'(1));
        check("timeout.strobes", 64'(o.strobes),  64'(TO));
        check("timeout.latency", 64'(o.lat),      64'(1 + TO));
        check("timeout.error",   64'(o.err),      64'(1));
        check("timeout.rdata",   64'(o.rdata),    64'(0));
        check("timeout.idle",    64'({o.ready_after, o.done_after}), 64'(2'b10));
        run_txn(LDI, 16'h4000, 16'h0000, 0, 1000, o);
        check("timeout2.strobes", 64'(o.strobes), 64'(1 + TO));
        check("timeout2.error",   64'(o.err),     64'(1));
        check("timeout2.rdata",   64'(o.rdata),   64'(0));
`else
        mem[16'h0600] = 16'h9999;
        run_txn(LDW, 16'h0601, 16'h0000, 9, 0, o);
        check("longwait.done",    64'(o.got_done), 64'(1));
        check("longwait.strobes", 64'(o.strobes),  64'(10));
        check("longwait.latency", 64'(o.lat),      64'(11));
        check("longwait.error",   64'(o.err),      64'(0));
        check("longwait.rdata",   64'(o.rdata),    64'(16'h9999));
`endif

        for (int a = 0; a < 64; a += LANES) mem[16'h0800 + AW'(a)] = DW'($urandom);
        for (int a = 0; a < 16; a += LANES) mem[16'h0800 + AW'(a)] = 16'h0800 | DW'($urandom_range(0, 63));
        for (int n = 0; n < 40; n++) begin
            logic [2:0] op;
            logic [AW-1:0] addr;
            logic [DW-1:0] wdata;
            int d1, d2;
            op    = 3'($urandom_range(0, 7));
            addr  = 16'h0800 + AW'($urandom_range(0, 63));
            wdata = DW'($urandom);
            d1    = $urandom_range(0, 2);
            d2    = $urandom_range(0, 2);
            e = model(op, addr, wdata, d1, d2);
            run_txn(op, addr, wdata, d1, d2, o);
            cmp($sformatf("rand%0d_op%0d", n, op), op, e, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_seq.md
MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, memory word width in bits; multiple of 8, >= 16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum wait for mem_resp per access; >= 1.
REQ-004 SHALL derive LANES = DATA_WIDTH/8 and LSB = clog2(LANES) internally.
REQ-005 SHALL have clk  input  1  sole clock, all state updates on posedge.
REQ-006 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have req_valid  input  1  request present.
REQ-008 SHALL have req_ready  output  1  sequencer idle, request may be accepted.
REQ-009 SHALL have req_op  input  3  0 LDW, 1 LDB, 2 LDI, 3 STW, 4 STB, 5 STI, 6-7 illegal.
REQ-010 SHALL have req_addr  input  ADDR_WIDTH  byte address.
REQ-011 SHALL have req_wdata  input  DATA_WIDTH  store data.
REQ-012 SHALL have done  output  1  one-cycle completion pulse.
REQ-013 SHALL have rdata  output  DATA_WIDTH  load result, valid while done=1.
REQ-014 SHALL have error  output  1  abort/illegal flag, valid while done=1.
REQ-015 SHALL have mem_address  output  ADDR_WIDTH, mem_read  output  1, mem_write  output  1, mem_wdata  output  DATA_WIDTH, mem_byte_enable  output  LANES, mem_rdata  input  DATA_WIDTH, mem_resp  input  1.

Function
REQ-016 SHALL use states IDLE, ACC1, ACC2, DONE; req_ready=1 only in IDLE.
REQ-017 SHALL, in IDLE with req_valid=1, register op/addr/wdata and go to ACC1 next cycle; otherwise stay IDLE.
REQ-018 SHALL, in ACC1, drive the first access: LDW/LDB read at addr; STW/STB write at addr; LDI/STI read pointer at addr.
REQ-019 SHALL hold mem_read/mem_write and mem_address stable in ACC1/ACC2 until the cycle mem_resp=1, then deassert them next cycle.
REQ-020 SHALL on mem_resp in ACC1 go to ACC2 for LDI/STI (capturing mem_rdata as pointer), else DONE.
REQ-021 SHALL in ACC2 read (LDI) or write (STI) at the captured pointer; on mem_resp go to DONE.
REQ-022 SHALL, for word accesses, drive mem_address with bits [LSB-1:0] cleared and mem_byte_enable all ones.
REQ-023 SHALL, for LDB, read word-aligned, select byte lane addr[LSB-1:0], zero-extend into rdata.
REQ-024 SHALL, for STB, replicate req_wdata[7:0] on every lane of mem_wdata and assert only lane addr[LSB-1:0] in mem_byte_enable.
REQ-025 SHALL register load data on mem_resp; rdata SHALL be 0 for stores.
REQ-026 SHALL pulse done for exactly the DONE cycle, then return to IDLE.
REQ-027 SHALL treat ops 6-7 as illegal: ACC1 skipped, no memory strobe, DONE next cycle with error=1, rdata=0.
REQ-028 SHALL ignore mem_resp in IDLE and DONE.
REQ-029 SHALL give latency from accept to done of 1+N cycles for single access (N = cycles strobe held, min 1), and sum of both access times plus 1 for LDI/STI.

Reset
REQ-030 SHALL on rst=1 enter IDLE next edge regardless of state, aborting any access without done.
REQ-031 SHALL reset outputs: req_ready=1 (after reset edge), done=0, error=0, rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=0.
REQ-032 SHALL ignore a mem_resp arriving after a mid-access reset.

Configuration
REQ-033 SHALL, with MEM_TIMEOUT_EN defined, count strobe cycles per access; if mem_resp absent after TIMEOUT_CYCLES cycles, drop strobe, go DONE with error=1, rdata=0.
REQ-034 SHALL, without MEM_TIMEOUT_EN, wait indefinitely; error asserted only for illegal ops; port list identical.

Verification
REQ-035 LDW addr 0x1235, mem_resp 1 cycle after strobe, mem_rdata 0xBEEF -> mem_address 0x1234, be 2'b11, done 2 cycles after accept, rdata 0xBEEF.
REQ-036 LDB addr 0x2001, mem_rdata 0xA55A -> be 2'b11, rdata 0x00A5; addr 0x2000 -> rdata 0x005A.
REQ-037 STB addr 0x3001 wdata 0x1234 -> mem_write, mem_wdata 0x3434, be 2'b10, done, rdata 0.
REQ-038 LDI addr 0x4000, first rdata 0x5000, second 0x0042 -> second mem_address 0x5000, rdata 0x0042, 3 cycles accept-to-done with 1-cycle responses.
REQ-039 STW with mem_resp withheld, rst pulsed after 3 strobe cycles -> mem_write low next cycle, no done, late mem_resp ignored, req_ready=1.
REQ-040 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no mem_resp -> strobe drops after 4 cycles, done and error pulse together; req_op 7 -> done with error=1, no strobe.
